// File: rtl/soc_io_pkg.sv
// Board I/O sizing shared between the input conditioner and the system top.
package soc_io_pkg;

  localparam int N_BTN = 5;
  localparam int N_SW  = 16;

  typedef logic [N_BTN-1:0] btn_vec_t;
  typedef logic [N_SW-1:0]  sw_vec_t;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: multi-flop synchroniser, tick-qualified stability counter,
// committed stable value and registered rise/fall pulses.
module debounce_cell #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchroniser chain would collapse to one stage otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == CW'(STABLE_TICKS - 1)) begin
          r_stable <= w_synced;
          r_cnt    <= '0;
          r_rise   <= w_synced;
          r_fall   <= ~w_synced;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the push-buttons and slide switches; one shared
// debounce-tick prescaler drives an independent cell per input bit.
module input_conditioner #(
  parameter int N_BTN        = soc_io_pkg::N_BTN,
  parameter int N_SW         = soc_io_pkg::N_SW,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (TICK_DIV < 1) begin : g_chk_div
    $error("input_conditioner: TICK_DIV must be >= 1");
  end
  if (STABLE_TICKS < 1) begin : g_chk_stable
    $error("input_conditioner: STABLE_TICKS must be >= 1");
  end

  logic [PW-1:0]   r_presc;
  logic            w_tick;
  logic [N_SW-1:0] w_sw_rise;
  logic [N_SW-1:0] w_sw_fall;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (w_tick),
      .i_raw   (btn_raw[i]),
      .o_level (btn_level[i]),
      .o_rise  (btn_press[i]),
      .o_fall  (btn_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (w_tick),
      .i_raw   (sw_raw[i]),
      .o_level (sw_level[i]),
      .o_rise  (w_sw_rise[i]),
      .o_fall  (w_sw_fall[i])
    );
  end

  // Rise and fall are registered and mutually exclusive per bit, so the OR is glitch-free.
  assign sw_changed = w_sw_rise | w_sw_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a short debounce window
// (SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3 -> commit latency 11..14 cycles).
module tb_input_conditioner;

  localparam int NB = 5;
  localparam int NS = 16;
  localparam int LAT_MIN = 11;
  localparam int LAT_MAX = 14;
  localparam int LAT_BOUND = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NS-1:0] sw_raw = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  logic [NS-1:0] sw_level, sw_changed;

  int n_checks = 0;
  int n_errors = 0;

  input_conditioner #(
    .N_BTN        (NB),
    .N_SW         (NS),
    .SYNC_STAGES  (2),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sw_level    (sw_level),
    .sw_changed  (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps until btn_level[idx]==target; counts any pulse on that bit seen before it.
  task automatic measure_btn(input int idx, input logic target, output int lat, output int early);
    lat = 0;
    early = 0;
    for (int k = 1; k <= LAT_BOUND; k++) begin
      @(posedge clk);
      #1;
      if (btn_level[idx] == target) begin
        lat = k;
        break;
      end
      if (btn_press[idx] || btn_release[idx]) early++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_btn_level"}, 32'(btn_level), 32'h0);
    check({tag, "_btn_press"}, 32'(btn_press), 32'h0);
    check({tag, "_btn_release"}, 32'(btn_release), 32'h0);
    check({tag, "_sw_level"}, 32'(sw_level), 32'h0);
    check({tag, "_sw_changed"}, 32'(sw_changed), 32'h0);
  endtask

  initial begin
    int lat;
    int early;
    int bad;

    // 1: reset held with all pins high
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_outputs_zero("t1_in_reset");
    end
    rst = 1'b0;
    step(1);
    check_outputs_zero("t1_after_release");
    btn_raw = '0;
    sw_raw  = '0;
    step(12);
    check_outputs_zero("t1_quiet");

    // 2: btn0 pressed and held
    btn_raw[0] = 1'b1;
    measure_btn(0, 1'b1, lat, early);
    check("t2_commit_seen", 32'(lat != 0), 32'h1);
    check("t2_latency_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'h1);
    check("t2_no_early_pulse", 32'(early), 32'h0);
    check("t2_level", 32'(btn_level), 32'h01);
    check("t2_press", 32'(btn_press), 32'h01);
    check("t2_release", 32'(btn_release), 32'h0);
    step(1);
    check("t2_press_after", 32'(btn_press), 32'h0);
    check("t2_level_after", 32'(btn_level), 32'h01);

    // 3: btn1 glitch shorter than the window
    btn_raw[1] = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (btn_level[1] || btn_press[1] || btn_release[1]) bad++;
    end
    btn_raw[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (btn_level[1] || btn_press[1] || btn_release[1]) bad++;
    end
    check("t3_glitch_ignored", 32'(bad), 32'h0);
    check("t3_level", 32'(btn_level), 32'h01);

    // 4: btn0 released and held low
    btn_raw[0] = 1'b0;
    measure_btn(0, 1'b0, lat, early);
    check("t4_commit_seen", 32'(lat != 0), 32'h1);
    check("t4_latency_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'h1);
    check("t4_no_early_pulse", 32'(early), 32'h0);
    check("t4_level", 32'(btn_level), 32'h0);
    check("t4_release", 32'(btn_release), 32'h01);
    check("t4_press", 32'(btn_press), 32'h0);
    step(1);
    check("t4_release_after", 32'(btn_release), 32'h0);

    // 5: many switches change together
    sw_raw = 16'hA5C3;
    lat = 0;
    early = 0;
    for (int k = 1; k <= LAT_BOUND; k++) begin
      step(1);
      if (sw_level != '0) begin
        lat = k;
        break;
      end
      if (sw_changed != '0) early++;
    end
    check("t5_commit_seen", 32'(lat != 0), 32'h1);
    check("t5_latency_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'h1);
    check("t5_no_early_pulse", 32'(early), 32'h0);
    check("t5_sw_level", 32'(sw_level), 32'hA5C3);
    check("t5_sw_changed", 32'(sw_changed), 32'hA5C3);
    step(1);
    check("t5_sw_changed_after", 32'(sw_changed), 32'h0);
    check("t5_sw_level_after", 32'(sw_level), 32'hA5C3);

    // 6: reset mid-window discards progress
    btn_raw[2] = 1'b1;
    step(8);
    check("t6_level_before_rst", 32'(btn_level[2]), 32'h0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_outputs_zero("t6_in_reset");
    measure_btn(2, 1'b1, lat, early);
    check("t6_commit_seen", 32'(lat != 0), 32'h1);
    check("t6_latency_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'h1);
    check("t6_no_early_pulse", 32'(early), 32'h0);
    check("t6_press", 32'(btn_press), 32'h04);
    check("t6_level", 32'(btn_level), 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
